// File: rtl/text_cursor_writer.sv
`default_nettype none
// ============================================================================
// Module      : text_cursor_writer
// Description : Turns a byte stream into character-RAM writes on port B,
//               tracking the cursor and interpreting CR/LF/BS/TAB/FF. At the
//               bottom row it either wraps or scrolls through a circular
//               top-row offset, blanking the line that scrolls in.
// Revision    : 1.0 - initial release
// ============================================================================
module text_cursor_writer #(
  parameter int         ROW_W     = 8,
  parameter int         COL_W     = 8,
  parameter int         ADDR_W    = 16,
  parameter int         DEF_ROWS  = 128,
  parameter int         DEF_COLS  = 160,
  parameter int         TAB_W     = 8,
  parameter bit         SCROLL_EN = 1'b1,
  parameter logic [7:0] BLANK     = 8'h20
) (
  input  logic              CLK_DATA,
  input  logic              reset,
  input  logic [ROW_W-1:0]  max_rows,
  input  logic [COL_W-1:0]  max_columns,
  input  logic              geom_update,
  input  logic [7:0]        data,
  input  logic              data_en,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic [ROW_W-1:0]  scroll_base,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CLR_LINE = 2'd1;
  localparam logic [1:0] CLR_ALL  = 2'd2;

  localparam logic [COL_W-1:0] c_tab_mask = COL_W'(TAB_W - 1);

  logic [1:0]        r_state;
  logic [ROW_W-1:0]  r_rows, r_row, r_base;
  logic [COL_W-1:0]  r_cols, r_col;
  logic [ADDR_W-1:0] r_clr_addr, r_clr_last;
  logic              r_ram_en;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_wdata;

  logic [ROW_W:0]    w_phys_sum, w_phys_full;
  logic [ROW_W-1:0]  w_phys, w_base_inc, w_g_rows, w_nxt_row;
  logic [COL_W-1:0]  w_g_cols, w_col_max, w_tab, w_nxt_col;
  logic [COL_W:0]    w_tab_full;
  logic [ADDR_W-1:0] w_addr, w_area_last, w_g_last, w_line_start, w_line_last;
  logic              w_write, w_adv, w_scroll, w_ff;

  // Address mapping, wrap helpers and clear-sweep bounds
  always_comb begin
    w_phys_sum   = {1'b0, r_row} + {1'b0, r_base};
    w_phys_full  = (w_phys_sum >= {1'b0, r_rows}) ? (w_phys_sum - {1'b0, r_rows}) : w_phys_sum;
    w_phys       = w_phys_full[ROW_W-1:0];
    w_addr       = ADDR_W'(w_phys) * ADDR_W'(r_cols) + ADDR_W'(r_col);
    w_base_inc   = (r_base == r_rows - ROW_W'(1)) ? '0 : r_base + ROW_W'(1);
    w_area_last  = ADDR_W'(r_rows) * ADDR_W'(r_cols) - ADDR_W'(1);
    w_line_start = ADDR_W'(r_base) * ADDR_W'(r_cols);
    w_line_last  = w_line_start + ADDR_W'(r_cols) - ADDR_W'(1);
    w_g_rows     = (max_rows == '0) ? ROW_W'(1) : max_rows;
    w_g_cols     = (max_columns == '0) ? COL_W'(1) : max_columns;
    w_g_last     = ADDR_W'(w_g_rows) * ADDR_W'(w_g_cols) - ADDR_W'(1);
    w_col_max    = r_cols - COL_W'(1);
    w_tab_full   = {1'b0, r_col | c_tab_mask} + (COL_W+1)'(1);
    w_tab        = (w_tab_full > {1'b0, w_col_max}) ? w_col_max : w_tab_full[COL_W-1:0];
  end

  // Decode the offered byte into a write request and the next cursor position
  always_comb begin
    w_nxt_row = r_row;
    w_nxt_col = r_col;
    w_write   = 1'b0;
    w_adv     = 1'b0;
    w_scroll  = 1'b0;
    w_ff      = 1'b0;
    case (data)
      8'h0D: w_nxt_col = '0;
      8'h0A: begin
        w_nxt_col = '0;
        w_adv     = 1'b1;
      end
      8'h08: if (r_col != '0) w_nxt_col = r_col - COL_W'(1);
      8'h09: w_nxt_col = w_tab;
      8'h0C: w_ff = 1'b1;
      default: begin
        w_write = 1'b1;
        if (r_col < w_col_max) begin
          w_nxt_col = r_col + COL_W'(1);
        end else begin
          w_nxt_col = '0;
          w_adv     = 1'b1;
        end
      end
    endcase
    if (w_adv) begin
      if (r_row < r_rows - ROW_W'(1)) begin
        w_nxt_row = r_row + ROW_W'(1);
      end else if (SCROLL_EN) begin
        w_scroll = 1'b1;
      end else begin
        w_nxt_row = '0;
      end
    end
  end

  // Cursor, geometry, scroll offset, clear sweep and registered RAM port
  always_ff @(posedge CLK_DATA or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rows      <= ROW_W'(DEF_ROWS);
      r_cols      <= COL_W'(DEF_COLS);
      r_row       <= '0;
      r_col       <= '0;
      r_base      <= '0;
      r_clr_addr  <= '0;
      r_clr_last  <= '0;
      r_ram_en    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_en <= 1'b0;
      if (geom_update) begin
        // New geometry always restarts with a full-screen clear
        r_rows     <= w_g_rows;
        r_cols     <= w_g_cols;
        r_row      <= '0;
        r_col      <= '0;
        r_base     <= '0;
        r_clr_addr <= '0;
        r_clr_last <= w_g_last;
        r_state    <= CLR_ALL;
      end else begin
        case (r_state)
          IDLE: begin
            if (data_en) begin
              r_row <= w_nxt_row;
              r_col <= w_nxt_col;
              if (w_write) begin
                r_ram_en    <= 1'b1;
                r_ram_addr  <= w_addr;
                r_ram_wdata <= data;
              end
              if (w_scroll) begin
                // The old top row becomes the new bottom row
                r_base     <= w_base_inc;
                r_clr_addr <= w_line_start;
                r_clr_last <= w_line_last;
                r_state    <= CLR_LINE;
              end
              if (w_ff) begin
                r_row      <= '0;
                r_col      <= '0;
                r_base     <= '0;
                r_clr_addr <= '0;
                r_clr_last <= w_area_last;
                r_state    <= CLR_ALL;
              end
            end
          end
          CLR_LINE, CLR_ALL: begin
            r_ram_en    <= 1'b1;
            r_ram_addr  <= r_clr_addr;
            r_ram_wdata <= BLANK;
            if (r_clr_addr == r_clr_last) begin
              r_state <= IDLE;
            end else begin
              r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign ram_en      = r_ram_en;
  assign ram_wen     = r_ram_en;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign scroll_base = r_base;
  assign cursor_row  = r_row;
  assign cursor_col  = r_col;

endmodule
`default_nettype wire

// File: tb/tb_text_cursor_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_cursor_writer
// Description : Bench for text_cursor_writer. Two instances share stimulus:
//               one scrolls (TAB_W=8), one wraps (TAB_W=2). A cycle-level
//               screen model predicts RAM writes into queues; a monitor pops
//               and compares them along with busy and cursor state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_cursor_writer;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  max_rows, max_columns, data;
  logic        geom_update, data_en;
  logic        busy0, ram_en0, ram_wen0, busy1, ram_en1, ram_wen1;
  logic [15:0] ram_addr0, ram_addr1;
  logic [7:0]  ram_wdata0, ram_wdata1, scroll_base0, scroll_base1;
  logic [7:0]  cursor_row0, cursor_row1, cursor_col0, cursor_col1;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  started = 1'b0;
  wr_t q0[$];
  wr_t q1[$];
  int  m_rows[2], m_cols[2], m_row[2], m_col[2], m_base[2], m_busy[2];

  always #5 clk = ~clk;

  text_cursor_writer #(.SCROLL_EN(1'b1), .TAB_W(8)) u_dut0 (
    .CLK_DATA(clk), .reset(reset), .max_rows(max_rows), .max_columns(max_columns),
    .geom_update(geom_update), .data(data), .data_en(data_en), .busy(busy0),
    .ram_en(ram_en0), .ram_wen(ram_wen0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
    .scroll_base(scroll_base0), .cursor_row(cursor_row0), .cursor_col(cursor_col0));

  text_cursor_writer #(.SCROLL_EN(1'b0), .TAB_W(2), .DEF_ROWS(6), .DEF_COLS(7)) u_dut1 (
    .CLK_DATA(clk), .reset(reset), .max_rows(max_rows), .max_columns(max_columns),
    .geom_update(geom_update), .data(data), .data_en(data_en), .busy(busy1),
    .ram_en(ram_en1), .ram_wen(ram_wen1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .scroll_base(scroll_base1), .cursor_row(cursor_row1), .cursor_col(cursor_col1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // ---------------- reference model: screen-level rules ----------------
  task automatic push_wr(input int i, input int a, input int d, input int c);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = c;
    if (i == 0) q0.push_back(w); else q1.push_back(w);
  endtask

  task automatic flush(input int i);
    if (i == 0) q0.delete(); else q1.delete();
  endtask

  task automatic sweep(input int i, input int start, input int n);
    for (int k = 0; k < n; k++) push_wr(i, start + k, 8'h20, cyc + 1 + k);
    m_busy[i] = n;
  endtask

  task automatic model_reset(input int i);
    m_rows[i] = (i == 0) ? 128 : 6;
    m_cols[i] = (i == 0) ? 160 : 7;
    m_row[i] = 0; m_col[i] = 0; m_base[i] = 0; m_busy[i] = 0;
    flush(i);
  endtask

  task automatic model_step(input int i);
    int  d, tw, ob;
    bit  adv;
    tw  = (i == 0) ? 8 : 2;
    adv = 1'b0;
    if (geom_update) begin
      m_rows[i] = (max_rows == 0) ? 1 : int'(max_rows);
      m_cols[i] = (max_columns == 0) ? 1 : int'(max_columns);
      m_row[i] = 0; m_col[i] = 0; m_base[i] = 0;
      flush(i);
      sweep(i, 0, m_rows[i] * m_cols[i]);
    end else if (m_busy[i] > 0) begin
      m_busy[i]--;
    end else if (data_en) begin
      d = int'(data);
      case (d)
        'h0D: m_col[i] = 0;
        'h0A: begin m_col[i] = 0; adv = 1'b1; end
        'h08: if (m_col[i] > 0) m_col[i]--;
        'h09: begin
          m_col[i] = (m_col[i] | (tw - 1)) + 1;
          if (m_col[i] > m_cols[i] - 1) m_col[i] = m_cols[i] - 1;
        end
        'h0C: begin
          m_row[i] = 0; m_col[i] = 0; m_base[i] = 0;
          sweep(i, 0, m_rows[i] * m_cols[i]);
        end
        default: begin
          push_wr(i, ((m_row[i] + m_base[i]) % m_rows[i]) * m_cols[i] + m_col[i], d, cyc);
          if (m_col[i] < m_cols[i] - 1) m_col[i]++;
          else begin m_col[i] = 0; adv = 1'b1; end
        end
      endcase
      if (adv) begin
        if (m_row[i] < m_rows[i] - 1) m_row[i]++;
        else if (i == 0) begin
          ob = m_base[i];
          m_base[i] = (m_base[i] + 1) % m_rows[i];
          sweep(i, ob * m_cols[i], m_cols[i]);
        end else m_row[i] = 0;
      end
    end
  endtask

  // Advance the model on every active edge; async reset restores defaults
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      cyc++;
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- monitor ----------------
  task automatic mon(input int i, input logic b, input logic en, input logic wen,
                     input logic [15:0] a, input logic [7:0] wd, input logic [7:0] sb,
                     input logic [7:0] cr, input logic [7:0] cc);
    wr_t w;
    int  qs;
    chk($sformatf("busy%0d", i), 32'(b), 32'(m_busy[i] > 0));
    chk($sformatf("row%0d", i), 32'(cr), m_row[i]);
    chk($sformatf("col%0d", i), 32'(cc), m_col[i]);
    chk($sformatf("base%0d", i), 32'(sb), m_base[i]);
    qs = (i == 0) ? q0.size() : q1.size();
    if (en) begin
      chk($sformatf("wen%0d", i), 32'(wen), 1);
      if (qs == 0) begin
        fail($sformatf("unexpected_write%0d addr=%0d data=%0d", i, a, wd));
      end else begin
        w = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("waddr%0d", i), 32'(a), w.addr);
        chk($sformatf("wdata%0d", i), 32'(wd), w.data);
        chk($sformatf("wcyc%0d", i), cyc, w.cyc);
      end
    end else if (qs > 0) begin
      w = (i == 0) ? q0[0] : q1[0];
      if (w.cyc <= cyc) begin
        fail($sformatf("missing_write%0d addr=%0d", i, w.addr));
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      mon(0, busy0, ram_en0, ram_wen0, ram_addr0, ram_wdata0, scroll_base0, cursor_row0, cursor_col0);
      mon(1, busy1, ram_en1, ram_wen1, ram_addr1, ram_wdata1, scroll_base1, cursor_row1, cursor_col1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 500 && (busy0 || busy1); k++) tick();
    if (busy0 || busy1) fail("wait_idle_timeout");
  endtask

  task automatic send(input logic [7:0] b);
    wait_idle();
    data = b; data_en = 1'b1;
    tick();
    data_en = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int k = 0; k < s.len(); k++) send(s[k]);
  endtask

  task automatic geom(input int r, input int c);
    max_rows = 8'(r); max_columns = 8'(c); geom_update = 1'b1;
    tick();
    geom_update = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 19);
    case (r)
      0:       return 8'h0D;
      1, 2:    return 8'h0A;
      3, 4:    return 8'h08;
      5:       return 8'h09;
      6:       return ($urandom_range(0, 7) == 0) ? 8'h0C : 8'h41;
      default: return 8'($urandom_range(32, 126));
    endcase
  endfunction

  initial begin
    data = 8'h00; data_en = 1'b0; geom_update = 1'b0; max_rows = 8'd0; max_columns = 8'd0;
    #2 reset = 1'b1;
    #20;
    @(posedge clk); #1;
    reset = 1'b0;
    started = 1'b1;
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_ram_en0", 32'(ram_en0), 0);
    chk("rst_ram_addr0", 32'(ram_addr0), 0);
    chk("rst_ram_wdata0", 32'(ram_wdata0), 0);
    chk("rst_busy1", 32'(busy1), 0);

    // Basic printing with line wrap at 4x5
    geom(4, 5);
    wait_idle();
    send_str("ABCDEF");
    chk("abc_row", 32'(cursor_row0), 1);
    chk("abc_col", 32'(cursor_col0), 1);

    // Backspace saturation and tab stops
    geom(4, 5);
    wait_idle();
    send(8'h0A); send(8'h0A); send_str("xyz");
    for (int k = 0; k < 5; k++) send(8'h08);
    chk("bs_col", 32'(cursor_col0), 0);
    send(8'h09);
    chk("tab8_col", 32'(cursor_col0), 4);
    chk("tab2_col", 32'(cursor_col1), 2);

    // Bottom-right printable: scroll on instance 0, wrap on instance 1
    geom(4, 5);
    wait_idle();
    send(8'h0A); send(8'h0A); send(8'h0A); send_str("abcd");
    send("Z");
    send("Q");
    wait_idle();
    chk("scroll_base0", 32'(scroll_base0), 1);
    chk("scroll_base1", 32'(scroll_base1), 0);

    // Form feed with bytes offered while busy
    send(8'h0C);
    for (int k = 0; k < 10; k++) begin
      data = rand_byte(); data_en = 1'b1;
      tick();
    end
    data_en = 1'b0;
    wait_idle();

    // Geometry update mid-sweep, coinciding with a byte
    send(8'h0C);
    repeat (5) tick();
    max_rows = 8'd2; max_columns = 8'd3; geom_update = 1'b1; data = "K"; data_en = 1'b1;
    tick();
    geom_update = 1'b0; data_en = 1'b0;
    wait_idle();

    // Async reset in the middle of a line clear
    geom(4, 5);
    wait_idle();
    send(8'h0A); send(8'h0A); send(8'h0A); send_str("abcd");
    send("Z");
    tick(); tick();
    chk("pre_reset_busy0", 32'(busy0), 1);
    #3 reset = 1'b1;
    #1;
    chk("async_busy0", 32'(busy0), 0);
    chk("async_ram_en0", 32'(ram_en0), 0);
    chk("async_busy1", 32'(busy1), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    send(8'h0A);
    send("A");
    tick();

    // Randomized traffic on small geometries
    geom($urandom_range(1, 6), $urandom_range(1, 6));
    for (int k = 0; k < 1500; k++) begin
      geom_update = ($urandom_range(0, 99) == 0);
      max_rows    = 8'($urandom_range(0, 6));
      max_columns = 8'($urandom_range(0, 6));
      data_en     = ($urandom_range(0, 9) < 6);
      data        = rand_byte();
      tick();
    end
    geom_update = 1'b0; data_en = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
